// File: rtl/wavelet_accelerator_stream_packer.sv
// wavelet_accelerator_stream_packer
// Packs PACKET_WIDTH beats little-endian into WORD_WIDTH words. A word is
// closed when its last lane is filled or when in_last arrives, then queued in
// a small circular output FIFO together with per-lane strobes and a last flag.
// Optional build macro: WAVELET_PACKER_STATS_EN adds word_count and
// partial_count pop statistics.
module wavelet_accelerator_stream_packer #(
  parameter int WORD_WIDTH   = 32,
  parameter int PACKET_WIDTH = 8,
  parameter int OUT_DEPTH    = 2,
  localparam int LANES       = WORD_WIDTH / PACKET_WIDTH,
  localparam int LANE_W      = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PACKET_WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_WIDTH-1:0]   out_data,
  output logic [LANES-1:0]        out_strb,
  output logic                    out_last,
  output logic [LANE_W-1:0]       lane_ptr
`ifdef WAVELET_PACKER_STATS_EN
  ,
  output logic [31:0]             word_count,
  output logic [15:0]             partial_count
`endif
);

  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  logic [WORD_WIDTH-1:0] asm_data;
  logic [WORD_WIDTH-1:0] merged_data;
  logic [LANES-1:0]      asm_strb;
  logic [LANES-1:0]      merged_strb;

  logic [WORD_WIDTH-1:0] mem_data [OUT_DEPTH];
  logic [LANES-1:0]      mem_strb [OUT_DEPTH];
  logic                  mem_last [OUT_DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] fifo_count;

  logic accept;
  logic push;
  logic pop;

  // Circular pointer advance that wraps at OUT_DEPTH, not at a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (fifo_count < CNT_W'(OUT_DEPTH));
  assign out_valid = (fifo_count != '0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & (in_last | (lane_ptr == LANE_W'(LANES - 1)));
  assign pop       = out_valid & out_ready;

  // Head entry is presented only while valid so an empty FIFO shows zeros.
  assign out_data = out_valid ? mem_data[rd_ptr] : '0;
  assign out_strb = out_valid ? mem_strb[rd_ptr] : '0;
  assign out_last = out_valid ? mem_last[rd_ptr] : 1'b0;

  // Merge the incoming beat into the lane currently pointed to.
  always_comb begin
    merged_data = asm_data;
    merged_strb = asm_strb;
    merged_data[lane_ptr * PACKET_WIDTH +: PACKET_WIDTH] = in_data;
    merged_strb[lane_ptr] = 1'b1;
  end

  // Word assembly: accumulate beats, restart from lane 0 once a word closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_ptr <= '0;
      asm_data <= '0;
      asm_strb <= '0;
    end else if (clear || push) begin
      lane_ptr <= '0;
      asm_data <= '0;
      asm_strb <= '0;
    end else if (accept) begin
      lane_ptr <= lane_ptr + 1'b1;
      asm_data <= merged_data;
      asm_strb <= merged_strb;
    end
  end

  // FIFO pointers and occupancy; clear overrides any push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (clear) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage: the closing beat is merged and written on the same edge.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_data[wr_ptr] <= merged_data;
      mem_strb[wr_ptr] <= merged_strb;
      mem_last[wr_ptr] <= in_last;
    end
  end

`ifdef WAVELET_PACKER_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Pop statistics: total words (wrapping) and partial words (saturating).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count    <= '0;
      partial_count <= '0;
    end else if (clear) begin
      word_count    <= '0;
      partial_count <= '0;
    end else if (pop) begin
      word_count <= word_count + 32'd1;
      if (out_strb != '1) partial_count <= sat_inc16(partial_count);
    end
  end
`endif

endmodule
